hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order integer pipeline.
- Sits beside the ID stage and replaces fixed EX/MEM/WB destination-index compares with a scoreboard shift register of in-flight writers, NUM_STAGES deep.
- Produces the load-use/RAW stall, registered per-operand forwarding selects for EX, branch-flush squashing, and a stall-cycle performance counter.

---
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the in-order integer pipeline: a shift register of
// in-flight writers (entry 0 = ID/EX) drives the RAW stall and the registered EX forwarding selects.
module hazard_scoreboard #(
  parameter int NUM_STAGES  = 3,
  parameter int REG_IDX_W   = 5,
  parameter int LOAD_STAGE  = 2,
  parameter int FWD_EN      = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int SEL_W       = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_IDX_W-1:0]  id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_IDX_W-1:0]  id_rs2,
  input  logic                  id_rs2_used,
  input  logic [REG_IDX_W-1:0]  id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  flush_in,
  output logic                  stall_out,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic [NUM_STAGES-1:0] stage_busy,
  output logic [31:0]           stall_count
);

  logic [NUM_STAGES-1:0]                ent_valid;
  logic [NUM_STAGES-1:0][REG_IDX_W-1:0] ent_dest;
  logic [NUM_STAGES-1:0]                ent_load;

  logic a_hit, a_load, b_hit, b_load, haz_a, haz_b, issue, wr0;
  int   a_m, b_m;
  logic [SEL_W-1:0] sel_a, sel_b;

  // Youngest valid writer of idx wins: scan oldest to youngest so the last hit sticks.
  function automatic void find_match(
    input  logic                                 used,
    input  logic [REG_IDX_W-1:0]                 idx,
    input  logic [NUM_STAGES-1:0]                vld,
    input  logic [NUM_STAGES-1:0][REG_IDX_W-1:0] dst,
    input  logic [NUM_STAGES-1:0]                ld,
    output logic                                 hit,
    output logic                                 hit_load,
    output int                                   m
  );
    hit      = 1'b0;
    hit_load = 1'b0;
    m        = 0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (vld[i] && dst[i] == idx) begin
        hit      = 1'b1;
        hit_load = ld[i];
        m        = i;
      end
    end
    if (!used || idx == '0) begin
      hit      = 1'b0;
      hit_load = 1'b0;
    end
  endfunction

  function automatic logic is_hazard(input logic hit, input logic hit_load, input int m);
    if (FWD_EN != 0) return hit && hit_load && (m + 1 < LOAD_STAGE);
    return hit;
  endfunction

  // A match in the oldest entry reads the write-through register file, so select 0.
  function automatic logic [SEL_W-1:0] pick_sel(input logic hit, input int m);
    if (FWD_EN != 0 && hit && (m + 1 <= NUM_STAGES - 1)) return SEL_W'(m + 1);
    return '0;
  endfunction

  always_comb begin
    find_match(id_rs1_used, id_rs1, ent_valid, ent_dest, ent_load, a_hit, a_load, a_m);
    find_match(id_rs2_used, id_rs2, ent_valid, ent_dest, ent_load, b_hit, b_load, b_m);
    haz_a = is_hazard(a_hit, a_load, a_m);
    haz_b = is_hazard(b_hit, b_load, b_m);
    sel_a = pick_sel(a_hit, a_m);
    sel_b = pick_sel(b_hit, b_m);
  end

  // ID hands off to EX when id_valid & ~stall_out & ~flush_in; stall holds IF/ID and
  // drops a bubble into ID/EX, flush wins over stall.
  assign stall_out  = id_valid && (haz_a || haz_b) && !flush_in;
  assign issue      = id_valid && !stall_out && !flush_in;
  assign wr0        = issue && id_reg_wr && (id_rd != '0);
  assign stage_busy = ent_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_valid   <= '0;
      ent_dest    <= '0;
      ent_load    <= '0;
      fwd_a_sel   <= '0;
      fwd_b_sel   <= '0;
      stall_count <= '0;
    end else begin
      for (int i = NUM_STAGES - 1; i >= 1; i--) begin
        ent_valid[i] <= ent_valid[i-1];
        ent_dest[i]  <= ent_dest[i-1];
        ent_load[i]  <= ent_load[i-1];
      end
      ent_valid[0] <= wr0;
      ent_dest[0]  <= wr0 ? id_rd : '0;
      ent_load[0]  <= wr0 && id_is_load;
      if (flush_in) begin
        for (int i = 0; i < FLUSH_DEPTH; i++) begin
          ent_valid[i] <= 1'b0;
          ent_dest[i]  <= '0;
          ent_load[i]  <= 1'b0;
        end
      end
      fwd_a_sel <= issue ? sel_a : '0;
      fwd_b_sel <= issue ? sel_b : '0;
      if (stall_out && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding instance (defaults) and a
// no-forwarding instance share the same ID stimulus.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic       id_rs1_used;
  logic [4:0] id_rs2;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_wr;
  logic       id_is_load;
  logic       flush_in;

  logic        stall_f, stall_n;
  logic [1:0]  fwd_a_f, fwd_b_f, fwd_a_n, fwd_b_n;
  logic [2:0]  busy_f, busy_n;
  logic [31:0] cnt_f, cnt_n;

  int n_cmp = 0;
  int n_err = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .flush_in(flush_in), .stall_out(stall_f),
    .fwd_a_sel(fwd_a_f), .fwd_b_sel(fwd_b_f),
    .stage_busy(busy_f), .stall_count(cnt_f)
  );

  hazard_scoreboard #(.FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wr(id_reg_wr), .id_is_load(id_is_load),
    .flush_in(flush_in), .stall_out(stall_n),
    .fwd_a_sel(fwd_a_n), .fwd_b_sel(fwd_b_n),
    .stage_busy(busy_n), .stall_count(cnt_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_wr = wr; id_is_load = ld;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush_in = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    do_reset();
    check("reset_busy", 32'(busy_f), 32'd0);
    check("reset_fwd_a", 32'(fwd_a_f), 32'd0);
    check("reset_fwd_b", 32'(fwd_b_f), 32'd0);
    check("reset_count", cnt_f, 32'd0);
    check("reset_stall", 32'(stall_f), 32'd0);

    // load-use: lw x5 ; add x6,x5,x1
    drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1 check("lu_lw_nostall", 32'(stall_f), 32'd0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1 check("lu_stall", 32'(stall_f), 32'd1);
    check("lu_busy0", 32'(busy_f), 32'b001);
    tick();
    #1 check("lu_stall_released", 32'(stall_f), 32'd0);
    check("lu_busy1", 32'(busy_f), 32'b010);
    tick();
    idle();
    check("lu_fwd_a", 32'(fwd_a_f), 32'd2);
    check("lu_fwd_b", 32'(fwd_b_f), 32'd0);
    check("lu_count", cnt_f, 32'd1);
    check("lu_busy2", 32'(busy_f), 32'b101);

    // ALU back-to-back: add x3 ; sub x4,x3,x3
    do_reset();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    #1 check("alu_stall", 32'(stall_f), 32'd0);
    tick();
    idle();
    check("alu_fwd_a", 32'(fwd_a_f), 32'd1);
    check("alu_fwd_b", 32'(fwd_b_f), 32'd1);
    check("alu_busy", 32'(busy_f), 32'b011);
    check("alu_count", cnt_f, 32'd0);

    // writer to x0 then consumer of x0
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
    #1 check("x0_busy", 32'(busy_f), 32'b000);
    check("x0_stall", 32'(stall_f), 32'd0);
    check("x0_stall_nf", 32'(stall_n), 32'd0);
    tick();
    idle();
    check("x0_fwd_a", 32'(fwd_a_f), 32'd0);
    check("x0_fwd_b", 32'(fwd_b_f), 32'd0);
    check("x0_busy_after", 32'(busy_f), 32'b000);

    // flush with entries 0,1 valid and a load-use hazard in ID
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1);
    tick();
    check("fl_pre_fwd_a", 32'(fwd_a_f), 32'd1);
    check("fl_pre_busy", 32'(busy_f), 32'b011);
    drive(1'b1, 5'd11, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0);
    #1 check("fl_hazard_seen", 32'(stall_f), 32'd1);
    flush_in = 1'b1;
    #1 check("fl_stall_masked", 32'(stall_f), 32'd0);
    tick();
    idle();
    check("fl_busy", 32'(busy_f), 32'b100);
    check("fl_fwd_a", 32'(fwd_a_f), 32'd0);
    check("fl_fwd_b", 32'(fwd_b_f), 32'd0);
    check("fl_count", cnt_f, 32'd0);

    // no forwarding: add x7 then a use of x7 stalls three cycles
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("nf_stall_%0d", i), 32'(stall_n), 32'd1);
      tick();
    end
    #1 check("nf_issue", 32'(stall_n), 32'd0);
    tick();
    idle();
    check("nf_fwd_a", 32'(fwd_a_n), 32'd0);
    check("nf_count", cnt_n, 32'd3);
    check("nf_busy", 32'(busy_n), 32'b001);

    // asynchronous reset in the middle of a stall
    do_reset();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick();
    tick();
    check("rs_pre_count_nf", cnt_n, 32'd2);
    check("rs_pre_stall_nf", 32'(stall_n), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("rs_stall_nf", 32'(stall_n), 32'd0);
    check("rs_busy_nf", 32'(busy_n), 32'd0);
    check("rs_count_nf", cnt_n, 32'd0);
    check("rs_busy_f", 32'(busy_f), 32'd0);
    check("rs_count_f", cnt_f, 32'd0);
    idle();
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
